// File: rtl/keypad_scanner.sv
`default_nettype none
// keypad_scanner: 4x4 matrix keypad scanner with column synchroniser,
// per-key debounce, release detection and a valid/ack key-code handshake.
module keypad_scanner #(
  parameter int ROW_DWELL    = 100000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_down,
  output logic       key_overrun
);

  localparam int DW = $clog2(ROW_DWELL);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(ROW_DWELL - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    col_meta, col_sync;
  logic [DW-1:0] dwell_cnt;
  logic          dwell_end;
  logic [1:0]    row_idx, row_idx_nxt;
  logic [1:0]    cand_col, cand_col_nxt;
  logic [CW-1:0] deb_cnt, deb_cnt_nxt;
  logic [CW-1:0] rel_cnt, rel_cnt_nxt;
  logic [3:0]    code_nxt;
  logic          valid_nxt, down_nxt, overrun_nxt;
  logic          accept;
  logic [1:0]    low_col;
  logic          cand_level;

  // Column synchroniser and free-running dwell counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_meta  <= 4'b1111;
      col_sync  <= 4'b1111;
      dwell_cnt <= '0;
    end else begin
      col_meta  <= col;
      col_sync  <= col_meta;
      dwell_cnt <= (dwell_cnt == DWELL_LAST) ? '0 : dwell_cnt + DW'(1);
    end
  end

  assign dwell_end  = (dwell_cnt == DWELL_LAST);
  assign cand_level = col_sync[cand_col];
  assign row        = ~(4'b0001 << row_idx);

  always_comb begin
    low_col = 2'd0;
    if (!col_sync[0])      low_col = 2'd0;
    else if (!col_sync[1]) low_col = 2'd1;
    else if (!col_sync[2]) low_col = 2'd2;
    else if (!col_sync[3]) low_col = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SCAN;
      row_idx     <= 2'd0;
      cand_col    <= 2'd0;
      deb_cnt     <= '0;
      rel_cnt     <= '0;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_down    <= 1'b0;
      key_overrun <= 1'b0;
    end else begin
      state       <= state_nxt;
      row_idx     <= row_idx_nxt;
      cand_col    <= cand_col_nxt;
      deb_cnt     <= deb_cnt_nxt;
      rel_cnt     <= rel_cnt_nxt;
      key_code    <= code_nxt;
      key_valid   <= valid_nxt;
      key_down    <= down_nxt;
      key_overrun <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    row_idx_nxt  = row_idx;
    cand_col_nxt = cand_col;
    deb_cnt_nxt  = deb_cnt;
    rel_cnt_nxt  = rel_cnt;
    down_nxt     = key_down;
    accept       = 1'b0;

    case (state)
      SCAN: begin
        if (dwell_end) begin
          if (col_sync == 4'b1111) begin
            row_idx_nxt = row_idx + 2'd1;
          end else begin
            // The detection sample is the first debounce sample.
            cand_col_nxt = low_col;
            deb_cnt_nxt  = CNT_ONE;
            state_nxt    = DEBOUNCE;
            if (CNT_ONE == CNT_MAX) accept = 1'b1;
          end
        end
      end
      DEBOUNCE: begin
        if (dwell_end) begin
          if (!cand_level) begin
            deb_cnt_nxt = deb_cnt + CNT_ONE;
            if (deb_cnt + CNT_ONE == CNT_MAX) accept = 1'b1;
          end else begin
            row_idx_nxt = row_idx + 2'd1;
            state_nxt   = SCAN;
          end
        end
      end
      HELD: begin
        if (dwell_end) begin
          if (cand_level) begin
            rel_cnt_nxt = rel_cnt + CNT_ONE;
            if (rel_cnt + CNT_ONE == CNT_MAX) begin
              down_nxt    = 1'b0;
              row_idx_nxt = row_idx + 2'd1;
              state_nxt   = SCAN;
            end
          end else begin
            rel_cnt_nxt = '0;
          end
        end
      end
      default: state_nxt = SCAN;
    endcase

    if (accept) begin
      state_nxt   = HELD;
      rel_cnt_nxt = '0;
      down_nxt    = 1'b1;
    end
  end

  // Acceptance takes priority over a same-edge acknowledge.
  always_comb begin
    code_nxt    = key_code;
    valid_nxt   = key_valid;
    overrun_nxt = 1'b0;
    if (accept) begin
      code_nxt    = {row_idx, cand_col_nxt};
      valid_nxt   = 1'b1;
      overrun_nxt = key_valid && !key_ack;
    end else if (key_ack) begin
      valid_nxt = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// Bench for keypad_scanner: directed literal checks plus randomized column
// activity compared every cycle against a behavioural model.
module tb_keypad_scanner;

  localparam int ROW_DWELL    = 8;
  localparam int DEBOUNCE_CNT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row;
  logic [3:0] col = 4'b1111;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       key_down;
  logic       key_overrun;

  keypad_scanner #(.ROW_DWELL(ROW_DWELL), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_ack(key_ack), .key_down(key_down),
    .key_overrun(key_overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ed      = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int low_zero(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    return 0;
  endfunction

  // Behavioural model: plain integers, row kept as a rotating one-cold vector.
  logic [3:0] m_s1, m_s2, m_row, m_code;
  int         m_tick, m_phase, m_r, m_c, m_n, m_rel;
  bit         m_valid, m_down, m_ovr;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_s1 = 4'b1111; m_s2 = 4'b1111; m_tick = 0; m_row = 4'b1110;
        m_phase = 0; m_n = 0; m_rel = 0; m_r = 0; m_c = 0;
        m_code = 4'd0; m_valid = 0; m_down = 0; m_ovr = 0;
      end else begin
        logic [3:0] cs;
        bit acc;
        cs = m_s2;
        acc = 0;
        m_ovr = 0;
        if (m_tick % ROW_DWELL == ROW_DWELL - 1) begin
          case (m_phase)
            0: if (cs == 4'b1111) m_row = {m_row[2:0], m_row[3]};
               else begin
                 m_r = low_zero(m_row); m_c = low_zero(cs); m_n = 1; m_phase = 1;
                 if (m_n >= DEBOUNCE_CNT) acc = 1;
               end
            1: if (!cs[m_c]) begin
                 m_n++;
                 if (m_n == DEBOUNCE_CNT) acc = 1;
               end else begin
                 m_phase = 0; m_row = {m_row[2:0], m_row[3]};
               end
            default: if (cs[m_c]) begin
                 m_rel++;
                 if (m_rel == DEBOUNCE_CNT) begin
                   m_down = 0; m_phase = 0; m_row = {m_row[2:0], m_row[3]};
                 end
               end else m_rel = 0;
          endcase
        end
        if (acc) begin
          m_ovr = m_valid && !key_ack;
          m_code = 4'(4 * m_r + m_c);
          m_valid = 1; m_down = 1; m_rel = 0; m_phase = 2;
        end else if (key_ack) begin
          m_valid = 0;
        end
        m_s2 = m_s1;
        m_s1 = col;
        m_tick++;
      end
      started = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("row", 32'(row), 32'(m_row));
        check("key_code", 32'(key_code), 32'(m_code));
        check("key_valid", 32'(key_valid), 32'(m_valid));
        check("key_down", 32'(key_down), 32'(m_down));
        check("key_overrun", 32'(key_overrun), 32'(m_ovr));
      end
    end
  end

  // Advance to 2 time units after the k-th edge following reset release.
  task automatic adv_to(input int k);
    while (ed < k) begin
      @(posedge clk);
      ed++;
    end
    #2;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    ed = 0;
    check("rst_row", 32'(row), 32'h0000000e);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_down", 32'(key_down), 32'd0);
    check("rst_ovr", 32'(key_overrun), 32'd0);

    adv_to(8);  check("row_step1", 32'(row), 32'h0000000d);
    adv_to(16); check("row_step2", 32'(row), 32'h0000000b);
    col = 4'b1101;
    adv_to(39); check("k9_valid_early", 32'(key_valid), 32'd0);
    adv_to(40);
    check("k9_valid", 32'(key_valid), 32'd1);
    check("k9_code", 32'(key_code), 32'd9);
    check("k9_down", 32'(key_down), 32'd1);
    check("k9_row", 32'(row), 32'h0000000b);
    key_ack = 1'b1;
    adv_to(41);
    key_ack = 1'b0;
    check("ack_valid", 32'(key_valid), 32'd0);
    check("ack_code", 32'(key_code), 32'd9);
    col = 4'b1111;
    adv_to(56); col = 4'b1101;
    adv_to(64); col = 4'b1111;
    adv_to(87);
    check("rel_down_early", 32'(key_down), 32'd1);
    check("rel_row_early", 32'(row), 32'h0000000b);
    adv_to(88);
    check("rel_down", 32'(key_down), 32'd0);
    check("rel_row", 32'(row), 32'h00000007);
    adv_to(96); col = 4'b0110;
    adv_to(120);
    check("k0_code", 32'(key_code), 32'd0);
    check("k0_valid", 32'(key_valid), 32'd1);
    check("k0_ovr", 32'(key_overrun), 32'd0);
    col = 4'b1111;
    adv_to(160); col = 4'b0111;
    adv_to(184);
    check("k15_code", 32'(key_code), 32'd15);
    check("k15_valid", 32'(key_valid), 32'd1);
    check("k15_ovr", 32'(key_overrun), 32'd1);
    adv_to(185);
    check("k15_ovr_end", 32'(key_overrun), 32'd0);
    check("k15_valid_hold", 32'(key_valid), 32'd1);

    // Randomized column activity, acks and occasional resets.
    for (int seg = 0; seg < 200; seg++) begin
      int sel, len;
      sel = $urandom_range(0, 99);
      if (sel < 50) col = 4'b1111;
      else if (sel < 85) col = ~(4'b0001 << $urandom_range(0, 3));
      else col = 4'($urandom);
      len = $urandom_range(1, 50);
      for (int i = 0; i < len; i++) begin
        key_ack = ($urandom_range(0, 9) == 0);
        reset   = ($urandom_range(0, 1499) == 0);
        adv_to(ed + 1);
      end
    end
    reset = 1'b0;
    key_ack = 1'b0;
    adv_to(ed + 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
